// File: rtl/tt_um_pwm_multich.sv
`default_nettype none
// ============================================================================
// Module      : tt_um_pwm_multich
// Description : N-channel PWM / RC-servo generator. One shared prescaler and
//               frame counter drive CH magnitude comparators. Duty values are
//               written into a shadow bank and copied to the active bank only
//               at the frame boundary, so a frame never sees a partial update.
// Ports       : clk          system clock
//               rst_n        asynchronous active-low reset
//               ena          run enable (counters freeze, outputs idle when 0)
//               mode         0 = PWM, 1 = servo; sampled at the frame boundary
//               wr_en        duty write strobe
//               wr_addr      channel index of the write
//               wr_data      duty value
//               pwm_out      registered PWM outputs (idle level = INV)
//               frame_start  one-clock pulse on the first cycle of each frame
// Revision    : 1.0 - initial release
// ============================================================================
module tt_um_pwm_multich #(
    parameter int              CH         = 4,
    parameter int              DW         = 8,
    parameter int              PW         = 16,
    parameter int              PRE_PWM    = 39,
    parameter int              PRE_SERVO  = 780,
    parameter int              SERVO_MIN  = 13,
    parameter int              SERVO_SPAN = 13,
    parameter logic [CH-1:0]   INV        = '0,
    localparam int             AW         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               mode,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [DW-1:0]      wr_data,
    output logic [CH-1:0]      pwm_out,
    output logic               frame_start
);

    localparam logic [PW-1:0] C_LIM_PWM   = PW'(PRE_PWM);
    localparam logic [PW-1:0] C_LIM_SERVO = PW'(PRE_SERVO);
    localparam logic [DW-1:0] C_FCNT_LAST = {DW{1'b1}};
    localparam int            C_PROD_W    = DW + 5;

    logic [PW-1:0] r_pre_cnt;
    logic [DW-1:0] r_fcnt;
    logic          r_mode_q;
    logic [DW-1:0] r_shadow [CH];
    logic [DW-1:0] r_active [CH];

    logic [PW-1:0] w_lim;
    logic          w_tick;
    logic          w_boundary;
    logic [CH-1:0] w_raw;

    // The prescaler limit follows the mode latched for the current frame, so a
    // mode change on the input never alters the length of a running frame.
    assign w_lim      = r_mode_q ? C_LIM_SERVO : C_LIM_PWM;
    assign w_tick     = ena && (r_pre_cnt == w_lim);
    assign w_boundary = w_tick && (r_fcnt == C_FCNT_LAST);

    // ------------------------------------------------------------------------
    // Shared timebase: prescaler, frame counter, latched mode, frame pulse.
    // The prescaler is always 0 after a boundary tick, so the new limit takes
    // effect from a clean start.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt   <= '0;
            r_fcnt      <= '0;
            r_mode_q    <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_boundary;
            if (ena) begin
                r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
            end
            if (w_tick) begin
                r_fcnt <= r_fcnt + 1'b1;
            end
            if (w_boundary) begin
                r_mode_q <= mode;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Duty double buffer. Writes land in the shadow bank whether or not the
    // generator runs; an address with no matching channel writes nothing.
    // The active bank copies the pre-write shadow contents, so a write that
    // coincides with the boundary is deferred by a full frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (wr_en && (wr_addr == AW'(i))) begin
                    r_shadow[i] <= wr_data;
                end
                if (w_boundary) begin
                    r_active[i] <= r_shadow[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel threshold and compare. The threshold is one bit wider than
    // the frame counter so servo floor plus span cannot wrap. In servo mode
    // the full duty*span product is kept before the shift to avoid losing
    // high-order bits.
    // ------------------------------------------------------------------------
    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [C_PROD_W-1:0] w_prod;
        logic [DW:0]         w_thr;

        assign w_prod   = C_PROD_W'(r_active[g]) * C_PROD_W'(SERVO_SPAN);
        assign w_thr    = r_mode_q ? ((DW+1)'(SERVO_MIN) + (DW+1)'(w_prod >> DW))
                                   : {1'b0, r_active[g]};
        assign w_raw[g] = ({1'b0, r_fcnt} < w_thr);
    end : g_ch

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_out <= INV;
        end else begin
            pwm_out <= ena ? (w_raw ^ INV) : INV;
        end
    end

endmodule : tt_um_pwm_multich
`default_nettype wire
